// File: rtl/subtractor_4bit_if.sv
// Operand/result bundle for the registered ripple-borrow subtractor.
// The master side supplies operands; the slave side returns the registered difference and flags.
interface subtractor_4bit_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             borrow_in;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             overflow;
  logic             zero;
  logic             out_valid;

  modport master (
    output in_valid, a, b, borrow_in,
    input  diff, borrow_out, overflow, zero, out_valid
  );

  modport slave (
    input  in_valid, a, b, borrow_in,
    output diff, borrow_out, overflow, zero, out_valid
  );
endinterface

// File: rtl/subtractor_4bit.sv
// Registered a - b - borrow_in built from a ripple chain of full-subtractor cells,
// with unsigned borrow, signed overflow and zero flags captured alongside the difference.
module subtractor_4bit #(
  parameter int WIDTH = 4
) (
  input logic               clk,
  input logic               rst_n,
  subtractor_4bit_if.slave  bus
);

  // Returns {bout, d} for one full-subtractor cell.
  function automatic logic [1:0] fsub_cell(input logic x, input logic y, input logic bin);
    logic d;
    logic bout;
    d    = x ^ y ^ bin;
    bout = (~x & y) | (~(x ^ y) & bin);
    return {bout, d};
  endfunction

  // Signed overflow: operands of opposite sign and a result whose sign left the minuend's.
  function automatic logic sub_overflow(input logic a_msb, input logic b_msb, input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

  // ---- stage p0: combinational ripple-borrow chain ----
  logic [WIDTH-1:0] diff_p0;
  logic             borrow_p0;
  logic             overflow_p0;
  logic             zero_p0;

  always_comb begin
    logic       bin_v;
    logic [1:0] cell_v;
    bin_v   = bus.borrow_in;
    cell_v  = 2'b00;
    diff_p0 = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cell_v     = fsub_cell(bus.a[i], bus.b[i], bin_v);
      diff_p0[i] = cell_v[0];
      bin_v      = cell_v[1];
    end
    borrow_p0   = bin_v;
    overflow_p0 = sub_overflow(bus.a[WIDTH-1], bus.b[WIDTH-1], diff_p0[WIDTH-1]);
    zero_p0     = (diff_p0 == '0);
  end

  // ---- stage p1: result registers ----
  logic [WIDTH-1:0] diff_p1;
  logic             borrow_p1;
  logic             overflow_p1;
  logic             zero_p1;
  logic             vld_p1;

  // Every register clears on reset so a downstream consumer never sees stale flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_p1     <= '0;
      borrow_p1   <= 1'b0;
      overflow_p1 <= 1'b0;
      zero_p1     <= 1'b0;
      vld_p1      <= 1'b0;
    end else begin
      vld_p1 <= bus.in_valid;
      if (bus.in_valid) begin
        diff_p1     <= diff_p0;
        borrow_p1   <= borrow_p0;
        overflow_p1 <= overflow_p0;
        zero_p1     <= zero_p0;
      end
    end
  end

  assign bus.diff       = diff_p1;
  assign bus.borrow_out = borrow_p1;
  assign bus.overflow   = overflow_p1;
  assign bus.zero       = zero_p1;
  assign bus.out_valid  = vld_p1;

endmodule

// File: tb/tb_subtractor_4bit.sv
// Directed and exhaustive bench for subtractor_4bit: integer-arithmetic reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_subtractor_4bit;
  localparam int WIDTH = 4;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  bit   chk_en;

  subtractor_4bit_if #(.WIDTH(WIDTH)) bus ();

  subtractor_4bit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer subtraction.
  function automatic int udiff(input logic [3:0] x, input logic [3:0] y, input logic bin);
    return int'(x) - int'(y) - int'(bin);
  endfunction

  function automatic int sdiff(input logic [3:0] x, input logic [3:0] y, input logic bin);
    return int'($signed(x)) - int'($signed(y)) - int'(bin);
  endfunction

  logic [3:0] m_diff;
  logic       m_borrow, m_ovf, m_zero, m_valid;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_diff   <= 4'd0;
      m_borrow <= 1'b0;
      m_ovf    <= 1'b0;
      m_zero   <= 1'b0;
      m_valid  <= 1'b0;
    end else begin
      m_valid <= bus.in_valid;
      if (bus.in_valid) begin
        m_diff   <= 4'(udiff(bus.a, bus.b, bus.borrow_in));
        m_borrow <= (udiff(bus.a, bus.b, bus.borrow_in) < 0);
        m_ovf    <= (sdiff(bus.a, bus.b, bus.borrow_in) < -8) || (sdiff(bus.a, bus.b, bus.borrow_in) > 7);
        m_zero   <= ((udiff(bus.a, bus.b, bus.borrow_in) & 15) == 0);
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model-vs-DUT comparison on every falling edge once the bench is under way.
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_diff",      8'(bus.diff),       8'(m_diff));
      check("m_borrow",    8'(bus.borrow_out), 8'(m_borrow));
      check("m_overflow",  8'(bus.overflow),   8'(m_ovf));
      check("m_zero",      8'(bus.zero),       8'(m_zero));
      check("m_out_valid", 8'(bus.out_valid),  8'(m_valid));
    end
  end

  // Present operands 1 time unit after a rising edge, then move to 1 unit past the capturing edge.
  task automatic step(input logic v, input logic [3:0] x, input logic [3:0] y, input logic bin);
    bus.in_valid  = v;
    bus.a         = x;
    bus.b         = y;
    bus.borrow_in = bin;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [3:0] d, input logic bo,
                            input logic ov, input logic z, input logic v);
    check({name, ".diff"},   8'(bus.diff),       8'(d));
    check({name, ".borrow"}, 8'(bus.borrow_out), 8'(bo));
    check({name, ".ovf"},    8'(bus.overflow),   8'(ov));
    check({name, ".zero"},   8'(bus.zero),       8'(z));
    check({name, ".valid"},  8'(bus.out_valid),  8'(v));
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    chk_en        = 1'b0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = 4'd0;
    bus.b         = 4'd0;
    bus.borrow_in = 1'b0;
    #12;
    expect_out("reset0", 4'b0000, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;
    step(0, 4'd0, 4'd0, 0);
    expect_out("idle", 4'b0000, 0, 0, 0, 0);

    // Basic directed, borrow_in = 0
    step(1, 4'b0110, 4'b0011, 0); expect_out("b_6m3",  4'b0011, 0, 0, 0, 1);
    step(1, 4'b0100, 4'b0110, 0); expect_out("b_4m6",  4'b1110, 1, 0, 0, 1);
    step(1, 4'b1111, 4'b1111, 0); expect_out("b_FmF",  4'b0000, 0, 0, 1, 1);
    step(1, 4'b1000, 4'b0001, 0); expect_out("b_8m1",  4'b0111, 0, 1, 0, 1);
    step(1, 4'b0000, 4'b0001, 0); expect_out("b_0m1",  4'b1111, 1, 0, 0, 1);

    // Borrow-in
    step(1, 4'b0000, 4'b0000, 1); expect_out("bi_0m0", 4'b1111, 1, 0, 0, 1);
    step(1, 4'b0101, 4'b0100, 1); expect_out("bi_5m4", 4'b0000, 0, 0, 1, 1);

    // Signed overflow
    step(1, 4'b0111, 4'b1111, 0); expect_out("ov_7mm1", 4'b1000, 1, 1, 0, 1);
    step(1, 4'b0011, 4'b0001, 0); expect_out("ov_3m1",  4'b0010, 0, 0, 0, 1);

    // Handshake 1,1,0,1: results hold while in_valid is low
    step(1, 4'b1001, 4'b0010, 0); expect_out("hs0", 4'b0111, 0, 1, 0, 1);
    step(1, 4'b0010, 4'b0010, 0); expect_out("hs1", 4'b0000, 0, 0, 1, 1);
    step(0, 4'b1111, 4'b0000, 1); expect_out("hs2", 4'b0000, 0, 0, 1, 0);
    step(1, 4'b1010, 4'b0011, 1); expect_out("hs3", 4'b0110, 0, 1, 0, 1);

    // Asynchronous reset mid-cycle while out_valid is high
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("rst_async", 4'b0000, 0, 0, 0, 0);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    expect_out("rst_after", 4'b0000, 0, 0, 0, 0);

    // First edge after reset captures normally
    step(1, 4'b1100, 4'b0101, 0); expect_out("post_rst", 4'b0111, 0, 1, 0, 1);

    // Exhaustive sweep, checked by the model on every cycle
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int c = 0; c < 2; c++)
          step(1, 4'(x), 4'(y), 1'(c));

    step(0, 4'd0, 4'd0, 0);
    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
